// File: rtl/router_pkg.sv
// router_pkg: shared flit types, port indices, input FSM states and XY route helper for the mesh router.
package router_pkg;
    localparam int NUM_OF_PORTS = 5;
    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int EAST = 2;
    localparam int SOUTH = 3;
    localparam int WEST = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_COORD_W = 3;
    typedef enum logic [1:0] {
        FT_BODY = 2'b00,
        FT_HEAD = 2'b01,
        FT_TAIL = 2'b10,
        FT_HEADTAIL = 2'b11
    } flit_type_e;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACTIVE
    } in_state_e;
    typedef struct packed {
        flit_type_e ftype;
        logic [DEF_COORD_W-1:0] dst_x;
        logic [DEF_COORD_W-1:0] dst_y;
        logic [DEF_DATA_W-1:0] payload;
    } flit_t;
    // X is resolved before Y so routes never turn back into the X dimension
    function automatic logic [2:0] xy_route(input int dx, input int dy, input int mx, input int my);
        return dx > mx ? 3'(EAST) : dx < mx ? 3'(WEST) : dy > my ? 3'(NORTH) : dy < my ? 3'(SOUTH) : 3'(LOCAL);
    endfunction
endpackage

// File: rtl/router_fifo.sv
// router_fifo: single-clock input FIFO; a push while full is accepted only when a pop frees a slot in the same cycle.
module router_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic do_push, do_pop;
    always_comb begin
        empty = wp == rp;
        full = wp == {~rp[AW], rp[AW-1:0]};
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        dout = mem[rp[AW-1:0]];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/credit_xy_router.sv
// credit_xy_router: 5-port wormhole mesh router with input FIFOs, XY routing, per-output arbitration and credit flow control.
module credit_xy_router
    import router_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int COORD_W = 3,
    parameter int MY_X = 0,
    parameter int MY_Y = 0,
    parameter int BUF_DEPTH = 4,
    parameter int ARB_MODE = 0,
    localparam int P = NUM_OF_PORTS,
    localparam int FLIT_W = 2 + 2 * COORD_W + DATA_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [P-1:0][FLIT_W-1:0] i_flit,
    input  logic [P-1:0]            i_valid,
    output logic [P-1:0]            o_credit,
    output logic [P-1:0][FLIT_W-1:0] o_flit,
    output logic [P-1:0]            o_valid,
    input  logic [P-1:0]            i_credit,
    output logic [P-1:0]            o_err
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    logic [P-1:0][FLIT_W-1:0] head, sel_flit;
    logic [P-1:0][1:0] ft;
    logic [P-1:0][2:0] cur_rt, rt_q, rt_n, ptr, ptr_n;
    logic [P-1:0][CW-1:0] cnt, cnt_n;
    logic [P-1:0] empty, full, pop, snd, dis, req, gnt, bad, busy, busy_n, send_o, ovf;
    in_state_e st [P];
    in_state_e st_n [P];
    logic found;
    int w, idx;
    for (genvar g = 0; g < P; g++) begin : g_fifo
        router_fifo #(.WIDTH(FLIT_W), .DEPTH(BUF_DEPTH)) u_fifo (
            .clk(clk), .reset(reset), .push(i_valid[g]), .pop(pop[g]), .din(i_flit[g]),
            .dout(head[g]), .full(full[g]), .empty(empty[g])
        );
    end
    always_comb begin
        pop = '0;
        snd = '0;
        gnt = '0;
        send_o = '0;
        sel_flit = '0;
        busy_n = busy;
        ptr_n = ptr;
        rt_n = rt_q;
        st_n = st;
        found = 1'b0;
        w = 0;
        idx = 0;
        for (int p = 0; p < P; p++) begin
            ft[p] = head[p][FLIT_W-1 -: 2];
            cur_rt[p] = st[p] == ST_IDLE ? xy_route(int'(head[p][FLIT_W-3 -: COORD_W]),
                int'(head[p][FLIT_W-3-COORD_W -: COORD_W]), MY_X, MY_Y) : rt_q[p];
            bad[p] = p != LOCAL && cur_rt[p] == 3'(p);
            dis[p] = !empty[p] && st[p] == ST_IDLE && (!ft[p][0] || bad[p]);
            req[p] = !empty[p] && (st[p] == ST_WAIT || (st[p] == ST_IDLE && ft[p][0] && !bad[p]));
            rt_n[p] = st[p] == ST_IDLE ? cur_rt[p] : rt_q[p];
        end
        // a free output grants and forwards the head in the same cycle
        for (int o = 0; o < P; o++) begin
            found = 1'b0;
            w = 0;
            for (int k = 0; k < P; k++) begin
                idx = ARB_MODE != 0 ? k : (int'(ptr[o]) + k) % P;
                if (!busy[o] && !found && req[idx] && cur_rt[idx] == 3'(o)) begin
                    found = 1'b1;
                    w = idx;
                end
            end
            if (found) begin
                gnt[w] = 1'b1;
                busy_n[o] = 1'b1;
                ptr_n[o] = ARB_MODE != 0 ? ptr[o] : 3'((w + 1) % P);
            end
        end
        for (int p = 0; p < P; p++) begin
            snd[p] = !empty[p] && (st[p] == ST_ACTIVE || gnt[p]) && cnt[cur_rt[p]] != '0;
            pop[p] = snd[p] || dis[p];
            if (snd[p]) begin
                send_o[cur_rt[p]] = 1'b1;
                sel_flit[cur_rt[p]] = head[p];
                if (ft[p][1]) busy_n[cur_rt[p]] = 1'b0;
            end
            st_n[p] = gnt[p] ? (snd[p] && ft[p][1] ? ST_IDLE : ST_ACTIVE) :
                      req[p] && st[p] == ST_IDLE ? ST_WAIT :
                      st[p] == ST_ACTIVE && snd[p] && ft[p][1] ? ST_IDLE : st[p];
        end
        for (int o = 0; o < P; o++)
            cnt_n[o] = cnt[o] - CW'(send_o[o]) + CW'(i_credit[o] && (cnt[o] != CW'(BUF_DEPTH) || send_o[o]));
        ovf = i_valid & full & ~pop;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < P; p++) st[p] <= ST_IDLE;
            rt_q <= '0;
            busy <= '0;
            ptr <= '0;
            cnt <= {P{CW'(BUF_DEPTH)}};
            o_valid <= '0;
            o_flit <= '0;
            o_credit <= '0;
            o_err <= '0;
        end else begin
            st <= st_n;
            rt_q <= rt_n;
            busy <= busy_n;
            ptr <= ptr_n;
            cnt <= cnt_n;
            o_valid <= send_o;
            o_flit <= sel_flit;
            o_credit <= pop;
            o_err <= o_err | dis | ovf;
        end
    end
endmodule

// File: doc/credit_xy_router.md
# credit_xy_router

- Parametrised 5-port wormhole mesh router for the NoC.
- Successor to the on/off-handshake router, with these additions:
  - per-input FIFO buffering of configurable depth;
  - credit-based flow control;
  - dimension-ordered XY routing from head-flit coordinates;
  - per-output arbitration, selectable between round-robin and fixed priority.
- Instantiated once per mesh tile; port 0 connects to the local network interface.

## Interface
Parameters:
- DATA_W, 32, payload width per flit.
- COORD_W, 3, width of each X/Y coordinate.
- MY_X, 0, this router's X coordinate.
- MY_Y, 0, this router's Y coordinate.
- BUF_DEPTH, 4, input FIFO depth in flits; must be a power of two, ≥2.
- ARB_MODE, 0, output arbitration: 0 = round-robin, 1 = fixed priority (lowest port index wins).

Ports (P = 5; index 0 Local, 1 North, 2 East, 3 South, 4 West; FLIT_W = 2+2*COORD_W+DATA_W):
- clk, input, 1, single clock.
- reset, input, 1, asynchronous, active-high.
- i_flit, input, [P][FLIT_W], incoming flits; fields {type[1:0], dst_x, dst_y, payload}.
- i_valid, input, [P], flit present on i_flit.
- o_credit, output, [P], one-cycle pulse: one slot freed in that input FIFO.
- o_flit, output, [P][FLIT_W], outgoing flits, registered.
- o_valid, output, [P], o_flit valid, registered.
- i_credit, input, [P], one-cycle credit return from the downstream router.
- o_err, output, [P], sticky input-FIFO overflow flag.

## Operation
Flit types:
- 00 BODY, 01 HEAD, 10 TAIL, 11 HEADTAIL (single-flit packet).
- dst_x/dst_y are meaningful in HEAD/HEADTAIL only.

Input stage:
- i_valid writes the flit into that port's FIFO.
- A write while the FIFO is full drops the flit and sets o_err[p], which stays set until reset.

Route computation (XY), on the head of each FIFO when the port is not locked:
- dst_x > MY_X → East; dst_x < MY_X → West.
- Otherwise dst_y > MY_Y → North; dst_y < MY_Y → South; else Local.
- Comparisons are unsigned, COORD_W bits.

Per-input state machine:
- IDLE: FIFO head is HEAD/HEADTAIL. Compute route and request that output → WAIT.
- WAIT: on grant, lock input to output → ACTIVE. A HEADTAIL returns straight to IDLE once sent.
- ACTIVE: forward flits whenever the FIFO is non-empty and the output credit is >0. On sending a TAIL → IDLE.
- A BODY/TAIL at the FIFO head in IDLE is a protocol error: discard it, set o_err[p].

Output arbitration:
- An output holds its grant from HEAD until TAIL; flits of different packets never interleave.
- Round-robin: the pointer moves to one past the winner after a grant.
- Fixed priority: lowest requesting index wins.
- A U-turn (route equal to the input port) is permitted only for Local.

Credits:
- One counter per output, width clog2(BUF_DEPTH+1), reset to BUF_DEPTH.
- Sending a flit decrements; i_credit increments; both in the same cycle leave it unchanged.
- No flit is sent at 0. The counter never exceeds BUF_DEPTH; an extra i_credit at BUF_DEPTH is ignored.

## Timing
Reset values:
- o_valid=0, o_credit=0, o_err=0, o_flit=0.
- FIFOs empty, all inputs IDLE, credit counters = BUF_DEPTH, RR pointers = 0.

Reset asserted mid-packet:
- All state is cleared immediately and held in-flight flits are lost.
- Upstream and downstream credit counters are reset in the same cycle.

Latency:
- A flit sampled at edge t is in the FIFO after t.
- Route, arbitration and switch traversal are combinational in cycle t+1; o_valid/o_flit are registered at edge t+2.
- Minimum latency is 2 cycles; throughput is 1 flit/cycle/output.
- The HEAD and following flits are not delayed by an extra arbitration cycle: grant and send occur in the same cycle.

Credit return:
- o_credit[p] pulses in the cycle after the flit is popped (registered).
- Pops from an error discard also return a credit.

Simultaneous events:
- A write and a pop on the same FIFO in the same cycle are allowed when full.
- The pop frees the slot first, so no overflow is flagged.

## Structure
- Shared package router_pkg:
  - flit-type enum, port-index constants (LOCAL, NORTH, EAST, SOUTH, WEST), NUM_OF_PORTS = 5;
  - packed flit struct parametrised via localparam widths, and the input FSM state enum.
- Sub-module router_fifo: single-clock, depth/width parametrised, with push/pop/full/empty and same-cycle push-when-full-with-pop.
- Instantiate one router_fifo per input.
- Route logic, arbiters, credit counters and crossbar live in the top module.

## Test plan
- Single-flit HEADTAIL from Local with dst=(2,0), MY=(0,0) → appears on East 2 cycles later; Local o_credit pulses at cycle 2.
- 4-flit packet N→S alongside a 4-flit packet W→E → both forward at 1 flit/cycle with no interaction.
- Local and West both send 3-flit packets to East, ARB_MODE=0 → one whole packet, then the other, no interleaving; repeat with the RR pointer advanced → the order alternates.
- East downstream sends no i_credit and BUF_DEPTH=4 → exactly 4 flits leave, then stall; one i_credit pulse → exactly 1 more flit.
- Five writes to an input whose output is stalled, BUF_DEPTH=4 → 5th dropped, o_err=1 and stays 1; reset → o_err=0 and credits back to 4.
- BODY flit arriving at an idle input → discarded, o_err set, o_credit pulses, no output activity.
